// File: rtl/vreg_read_arbiter.sv
// Operand-read arbiter: spreads one instruction's vector/mask source reads over a banked
// vector register file and a single-port mask file, returning per-port data a cycle later.
module vreg_read_arbiter #(
  parameter int READ_PORTS = 4,
  parameter int MASK_PORTS = 2,
  parameter int NUM_BANKS  = 4,
  parameter int REG_IDX_W  = 6,
  parameter int MASK_IDX_W = 3,
  parameter int DATA_W     = 512
) (
  input  logic                                                CLK,
  input  logic                                                nRST,
  input  logic                                                flush,
  input  logic                                                req_valid,
  output logic                                                req_ready,
  input  logic [READ_PORTS*REG_IDX_W-1:0]                     req_vs,
  input  logic [READ_PORTS-1:0]                               req_ven,
  input  logic [MASK_PORTS*MASK_IDX_W-1:0]                    req_vm,
  input  logic [MASK_PORTS-1:0]                               req_men,
  output logic [NUM_BANKS-1:0]                                bank_ren,
  output logic [NUM_BANKS*(REG_IDX_W-$clog2(NUM_BANKS))-1:0]  bank_raddr,
  input  logic [NUM_BANKS*DATA_W-1:0]                         bank_rdata,
  output logic                                                mask_ren,
  output logic [MASK_IDX_W-1:0]                               mask_raddr,
  input  logic [DATA_W/8-1:0]                                 mask_rdata,
  output logic [READ_PORTS-1:0]                               dvalid,
  output logic [READ_PORTS*DATA_W-1:0]                        vreg_out,
  output logic [MASK_PORTS-1:0]                               mvalid,
  output logic [MASK_PORTS*DATA_W/8-1:0]                      vmask_out,
  output logic                                                no_conflict,
  output logic                                                last
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = REG_IDX_W - BANK_W;
  localparam int MASK_W = DATA_W / 8;

  // IDLE: no request held | ISSUE: granting the held request's pending reads
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                                state_q, state_d;
  logic [READ_PORTS-1:0][REG_IDX_W-1:0]  vs_q, vs_d;
  logic [MASK_PORTS-1:0][MASK_IDX_W-1:0] vm_q, vm_d;
  logic [READ_PORTS-1:0]                 pend_v_q, pend_v_d, dis_v_q, dis_v_d;
  logic [MASK_PORTS-1:0]                 pend_m_q, pend_m_d, dis_m_q, dis_m_d;
  logic                                  first_q, first_d;
  logic [READ_PORTS-1:0]                 dvalid_q, dvalid_d, vgnt_q, vgnt_d;
  logic [MASK_PORTS-1:0]                 mvalid_q, mvalid_d, mgnt_q, mgnt_d;
  logic [READ_PORTS-1:0][BANK_W-1:0]     vbank_q, vbank_d;
  logic                                  last_q, last_d, noconf_q, noconf_d;

  logic                                  issue_act, final_issue, accept;
  logic [READ_PORTS-1:0]                 gnt_v;
  logic [MASK_PORTS-1:0]                 gnt_m;
  logic [NUM_BANKS-1:0]                  ren_c;
  logic [NUM_BANKS-1:0][ROW_W-1:0]       raddr_c;
  logic                                  mren_c;
  logic [MASK_IDX_W-1:0]                 maddr_c;
  logic [NUM_BANKS-1:0][DATA_W-1:0]      rdata_w;
  logic [READ_PORTS-1:0][DATA_W-1:0]     vout_w;
  logic [MASK_PORTS-1:0][MASK_W-1:0]     mout_w;

  assign issue_act = (state_q == ISSUE) && !flush;

  // Per bank the lowest pending port wins; ports naming the same register share the read.
  always_comb begin : vgrant
    logic                 found;
    logic [REG_IDX_W-1:0] win;
    gnt_v   = '0;
    ren_c   = '0;
    raddr_c = '0;
    found   = 1'b0;
    win     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      found = 1'b0;
      win   = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
        if (!found && pend_v_q[p] && (vs_q[p][BANK_W-1:0] == BANK_W'(b))) begin
          found = 1'b1;
          win   = vs_q[p];
        end
      end
      if (found && issue_act) begin
        ren_c[b]   = 1'b1;
        raddr_c[b] = win[REG_IDX_W-1:BANK_W];
        for (int p = 0; p < READ_PORTS; p++) begin
          if (pend_v_q[p] && (vs_q[p] == win)) gnt_v[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin : mgrant
    logic                  found;
    logic [MASK_IDX_W-1:0] win;
    gnt_m   = '0;
    mren_c  = 1'b0;
    maddr_c = '0;
    found   = 1'b0;
    win     = '0;
    for (int p = 0; p < MASK_PORTS; p++) begin
      if (!found && pend_m_q[p]) begin
        found = 1'b1;
        win   = vm_q[p];
      end
    end
    if (found && issue_act) begin
      mren_c  = 1'b1;
      maddr_c = win;
      for (int p = 0; p < MASK_PORTS; p++) begin
        if (pend_m_q[p] && (vm_q[p] == win)) gnt_m[p] = 1'b1;
      end
    end
  end

  assign final_issue = issue_act && ((pend_v_q & ~gnt_v) == '0) && ((pend_m_q & ~gnt_m) == '0);
  assign req_ready   = !flush && ((state_q == IDLE) || final_issue);
  assign accept      = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    vs_d     = vs_q;
    vm_d     = vm_q;
    pend_v_d = pend_v_q & ~gnt_v;
    pend_m_d = pend_m_q & ~gnt_m;
    dis_v_d  = dis_v_q;
    dis_m_d  = dis_m_q;
    first_d  = 1'b0;
    // Disabled ports ride along with the first response so every port pulses once.
    dvalid_d = gnt_v | ((issue_act && first_q) ? dis_v_q : '0);
    mvalid_d = gnt_m | ((issue_act && first_q) ? dis_m_q : '0);
    vgnt_d   = gnt_v;
    mgnt_d   = gnt_m;
    vbank_d  = '0;
    for (int p = 0; p < READ_PORTS; p++) vbank_d[p] = vs_q[p][BANK_W-1:0];
    last_d   = final_issue;
    noconf_d = final_issue && first_q;
    if (final_issue) state_d = IDLE;
    if (accept) begin
      state_d  = ISSUE;
      vs_d     = req_vs;
      vm_d     = req_vm;
      pend_v_d = req_ven;
      pend_m_d = req_men;
      dis_v_d  = ~req_ven;
      dis_m_d  = ~req_men;
      first_d  = 1'b1;
    end
    if (flush) begin
      state_d  = IDLE;
      pend_v_d = '0;
      pend_m_d = '0;
      first_d  = 1'b0;
      dvalid_d = '0;
      mvalid_d = '0;
      vgnt_d   = '0;
      mgnt_d   = '0;
      last_d   = 1'b0;
      noconf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      vs_q     <= '0;
      vm_q     <= '0;
      pend_v_q <= '0;
      pend_m_q <= '0;
      dis_v_q  <= '0;
      dis_m_q  <= '0;
      first_q  <= 1'b0;
      dvalid_q <= '0;
      mvalid_q <= '0;
      vgnt_q   <= '0;
      mgnt_q   <= '0;
      vbank_q  <= '0;
      last_q   <= 1'b0;
      noconf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_q     <= vs_d;
      vm_q     <= vm_d;
      pend_v_q <= pend_v_d;
      pend_m_q <= pend_m_d;
      dis_v_q  <= dis_v_d;
      dis_m_q  <= dis_m_d;
      first_q  <= first_d;
      dvalid_q <= dvalid_d;
      mvalid_q <= mvalid_d;
      vgnt_q   <= vgnt_d;
      mgnt_q   <= mgnt_d;
      vbank_q  <= vbank_d;
      last_q   <= last_d;
      noconf_q <= noconf_d;
    end
  end

  assign rdata_w = bank_rdata;

  always_comb begin
    vout_w = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (vgnt_q[p]) vout_w[p] = rdata_w[vbank_q[p]];
    end
  end

  always_comb begin
    mout_w = '0;
    for (int p = 0; p < MASK_PORTS; p++) begin
      if (mgnt_q[p]) mout_w[p] = mask_rdata;
    end
  end

  assign bank_ren    = ren_c;
  assign bank_raddr  = raddr_c;
  assign mask_ren    = mren_c;
  assign mask_raddr  = maddr_c;
  assign dvalid      = dvalid_q;
  assign mvalid      = mvalid_q;
  assign vreg_out    = vout_w;
  assign vmask_out   = mout_w;
  assign last        = last_q;
  assign no_conflict = noconf_q;

endmodule

// File: tb/tb_vreg_read_arbiter.sv
// Bench for vreg_read_arbiter: directed scenarios plus random traffic against a
// schedule-level model that precomputes each request's issue rounds on accept.
module tb_vreg_read_arbiter;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [23:0]   req_vs = '0;
  logic [3:0]    req_ven = '0;
  logic [5:0]    req_vm = '0;
  logic [1:0]    req_men = '0;
  logic [3:0]    bank_ren;
  logic [15:0]   bank_raddr;
  logic [2047:0] bank_rdata = '0;
  logic          mask_ren;
  logic [2:0]    mask_raddr;
  logic [63:0]   mask_rdata = '0;
  logic [3:0]    dvalid;
  logic [2047:0] vreg_out;
  logic [1:0]    mvalid;
  logic [127:0]  vmask_out;
  logic          no_conflict;
  logic          last;

  vreg_read_arbiter dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs(req_vs), .req_ven(req_ven), .req_vm(req_vm), .req_men(req_men),
    .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
    .mask_ren(mask_ren), .mask_raddr(mask_raddr), .mask_rdata(mask_rdata),
    .dvalid(dvalid), .vreg_out(vreg_out), .mvalid(mvalid), .vmask_out(vmask_out),
    .no_conflict(no_conflict), .last(last)
  );

  always #5 CLK = ~CLK;

  // One issue round of a request, with the response it must produce a cycle later.
  typedef struct packed {
    logic [3:0]  gv;
    logic [1:0]  gm;
    logic [3:0]  ren;
    logic [15:0] raddr;
    logic        mren;
    logic [2:0]  maddr;
    logic [3:0]  dis_v;
    logic [1:0]  dis_m;
    logic [7:0]  bsel;
    logic        first;
    logic        lst;
  } ent_t;

  ent_t mq[$];
  ent_t rsp;
  bit   rsp_valid = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  // Splits a request into rounds: each bank serves its lowest remaining port's register,
  // every remaining port naming that same register rides along; masks likewise on one port.
  function automatic void schedule(input logic [23:0] vs, input logic [3:0] ven,
                                   input logic [5:0] vm, input logic [1:0] men);
    logic [3:0] rem_v;
    logic [1:0] rem_m;
    bit         first;
    bit         found;
    logic [5:0] win;
    logic [2:0] mwin;
    ent_t       e;
    rem_v = ven;
    rem_m = men;
    first = 1'b1;
    do begin
      e = '0;
      for (int b = 0; b < 4; b++) begin
        found = 1'b0;
        win   = '0;
        for (int p = 0; p < 4; p++)
          if (!found && rem_v[p] && (int'(vs[p*6 +: 2]) == b)) begin
            found = 1'b1;
            win   = vs[p*6 +: 6];
          end
        if (found) begin
          e.ren[b] = 1'b1;
          e.raddr[b*4 +: 4] = win[5:2];
          for (int p = 0; p < 4; p++)
            if (rem_v[p] && vs[p*6 +: 6] == win) e.gv[p] = 1'b1;
        end
      end
      found = 1'b0;
      mwin  = '0;
      for (int p = 0; p < 2; p++)
        if (!found && rem_m[p]) begin
          found = 1'b1;
          mwin  = vm[p*3 +: 3];
        end
      if (found) begin
        e.mren  = 1'b1;
        e.maddr = mwin;
        for (int p = 0; p < 2; p++)
          if (rem_m[p] && vm[p*3 +: 3] == mwin) e.gm[p] = 1'b1;
      end
      rem_v = rem_v & ~e.gv;
      rem_m = rem_m & ~e.gm;
      e.first = first;
      e.dis_v = first ? ~ven : 4'b0;
      e.dis_m = first ? ~men : 2'b0;
      for (int p = 0; p < 4; p++) e.bsel[p*2 +: 2] = vs[p*6 +: 2];
      e.lst = (rem_v == 4'b0) && (rem_m == 2'b0);
      mq.push_back(e);
      first = 1'b0;
    end while (rem_v != 4'b0 || rem_m != 2'b0);
  endfunction

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic step(input bit fl, input bit v, input logic [23:0] vs, input logic [3:0] ven,
                      input logic [5:0] vm, input logic [1:0] men);
    ent_t       cur;
    bit         busy;
    bit         exp_ready;
    int         bs;
    logic [511:0] ev;
    @(negedge CLK);
    flush     = fl;
    req_valid = v;
    req_vs    = vs;
    req_ven   = ven;
    req_vm    = vm;
    req_men   = men;
    for (int k = 0; k < 64; k++) bank_rdata[k*32 +: 32] = $urandom;
    mask_rdata = {$urandom, $urandom};
    #1;
    busy      = mq.size() > 0;
    cur       = busy ? mq[0] : '0;
    exp_ready = !fl && (mq.size() <= 1);
    chk("req_ready", req_ready, exp_ready);
    if (busy && !fl) begin
      chk("bank_ren", bank_ren, cur.ren);
      chk("bank_raddr", bank_raddr, cur.raddr);
      chk("mask_ren", mask_ren, cur.mren);
      chk("mask_raddr", mask_raddr, cur.maddr);
    end else begin
      chk("bank_ren_idle", bank_ren, 4'b0);
      chk("mask_ren_idle", mask_ren, 1'b0);
    end
    chk("dvalid", dvalid, rsp_valid ? (rsp.gv | rsp.dis_v) : 4'b0);
    chk("mvalid", mvalid, rsp_valid ? (rsp.gm | rsp.dis_m) : 2'b0);
    chk("last", last, rsp_valid && rsp.lst);
    chk("no_conflict", no_conflict, rsp_valid && rsp.first && rsp.lst);
    for (int p = 0; p < 4; p++) begin
      bs = int'(rsp.bsel[p*2 +: 2]);
      ev = (rsp_valid && rsp.gv[p]) ? bank_rdata[bs*512 +: 512] : '0;
      chk($sformatf("vreg_out%0d", p), vreg_out[p*512 +: 512], ev);
    end
    for (int p = 0; p < 2; p++)
      chk($sformatf("vmask_out%0d", p), vmask_out[p*64 +: 64],
          (rsp_valid && rsp.gm[p]) ? mask_rdata : 64'b0);
    if (fl) begin
      mq.delete();
      rsp_valid = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        rsp       = mq.pop_front();
        rsp_valid = 1'b1;
      end else begin
        rsp_valid = 1'b0;
      end
      if (v && exp_ready) schedule(vs, ven, vm, men);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_bank_ren"}, bank_ren, 4'b0);
    chk({tag, "_bank_raddr"}, bank_raddr, 16'b0);
    chk({tag, "_mask_ren"}, mask_ren, 1'b0);
    chk({tag, "_dvalid"}, dvalid, 4'b0);
    chk({tag, "_mvalid"}, mvalid, 2'b0);
    chk({tag, "_last"}, last, 1'b0);
    chk({tag, "_no_conflict"}, no_conflict, 1'b0);
    chk({tag, "_vreg_zero"}, vreg_out == '0, 1'b1);
    chk({tag, "_vmask_zero"}, vmask_out == '0, 1'b1);
  endtask

  initial begin
    logic [23:0] r_vs;
    logic [5:0]  r_vm;
    bit          r_fl, r_v;

    #1;
    rst_checks("reset");
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // no conflict: four distinct banks, one shared mask read
    step(1'b0, 1'b1, pk(1, 2, 3, 4), 4'hf, 6'o00, 2'b11);
    chk("nc_model_rounds", mq.size(), 1);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("nc_bank_ren", bank_ren, 4'b1111);
    chk("nc_bank_raddr", bank_raddr, 16'h0001);
    chk("nc_mask_ren", mask_ren, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("nc_dvalid", dvalid, 4'b1111);
    chk("nc_mvalid", mvalid, 2'b11);
    chk("nc_flag", no_conflict, 1'b1);
    chk("nc_last", last, 1'b1);
    idle(2);

    // three-way conflict on bank 1
    step(1'b0, 1'b1, pk(1, 5, 9, 2), 4'hf, 6'o00, 2'b00);
    chk("cf_model_rounds", mq.size(), 3);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("cf_bank_ren1", bank_ren, 4'b0110);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("cf_dvalid1", dvalid, 4'b1001);
    chk("cf_last1", last, 1'b0);
    chk("cf_nc1", no_conflict, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("cf_dvalid2", dvalid, 4'b0010);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("cf_dvalid3", dvalid, 4'b0100);
    chk("cf_last3", last, 1'b1);
    chk("cf_nc3", no_conflict, 1'b0);
    idle(2);

    // dedupe: all ports name v7, both masks name m3
    step(1'b0, 1'b1, pk(7, 7, 7, 7), 4'hf, 6'o33, 2'b11);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("dd_bank_ren", bank_ren, 4'b1000);
    chk("dd_bank_raddr", bank_raddr, 16'h1000);
    chk("dd_mask_raddr", mask_raddr, 3'd3);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("dd_dvalid", dvalid, 4'b1111);
    chk("dd_mvalid", mvalid, 2'b11);
    chk("dd_nc", no_conflict, 1'b1);
    idle(2);

    // disabled ports 1 and 3, ports 0 and 2 collide on bank 1
    step(1'b0, 1'b1, pk(1, 2, 5, 3), 4'b0101, 6'o12, 2'b00);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("ds_bank_ren", bank_ren, 4'b0010);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("ds_dvalid1", dvalid, 4'b1011);
    chk("ds_mvalid1", mvalid, 2'b11);
    chk("ds_last1", last, 1'b0);
    chk("ds_port1_zero", vreg_out[1*512 +: 512] == '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("ds_dvalid2", dvalid, 4'b0100);
    chk("ds_last2", last, 1'b1);
    idle(2);

    // back-to-back: B held valid while A takes two issue rounds
    step(1'b0, 1'b1, pk(1, 5, 2, 3), 4'hf, 6'o00, 2'b00);
    step(1'b0, 1'b1, pk(1, 2, 3, 4), 4'hf, 6'o00, 2'b11);
    chk("bb_ready_busy", req_ready, 1'b0);
    chk("bb_ren_a1", bank_ren, 4'b1110);
    step(1'b0, 1'b1, pk(1, 2, 3, 4), 4'hf, 6'o00, 2'b11);
    chk("bb_ready_final", req_ready, 1'b1);
    chk("bb_ren_a2", bank_ren, 4'b0010);
    chk("bb_dvalid_a1", dvalid, 4'b1101);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("bb_ren_b", bank_ren, 4'b1111);
    chk("bb_dvalid_a2", dvalid, 4'b0010);
    chk("bb_last_a", last, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("bb_dvalid_b", dvalid, 4'b1111);
    chk("bb_nc_b", no_conflict, 1'b1);
    idle(2);

    // flush during the second issue round of the conflict case
    step(1'b0, 1'b1, pk(1, 5, 9, 2), 4'hf, 6'o00, 2'b00);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    step(1'b1, 1'b1, pk(1, 2, 3, 4), 4'hf, 6'o00, 2'b11);
    chk("fl_ready", req_ready, 1'b0);
    chk("fl_dvalid1", dvalid, 4'b1001);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("fl_dvalid_after", dvalid, 4'b0);
    chk("fl_last_after", last, 1'b0);
    chk("fl_ready_after", req_ready, 1'b1);
    idle(2);

    // asynchronous reset in the middle of the conflict case
    step(1'b0, 1'b1, pk(1, 5, 9, 2), 4'hf, 6'o00, 2'b00);
    step(1'b0, 1'b0, '0, '0, '0, '0);
    #2;
    nRST = 1'b0;
    #1;
    rst_checks("midrst");
    mq.delete();
    rsp_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    idle(3);

    // random traffic with small register indices to force conflicts and sharing
    for (int c = 0; c < 3000; c++) begin
      r_fl = ($urandom_range(0, 99) < 3);
      r_v  = ($urandom_range(0, 99) < 70);
      for (int p = 0; p < 4; p++)
        r_vs[p*6 +: 6] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 11));
      for (int p = 0; p < 2; p++)
        r_vm[p*3 +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
      step(r_fl, r_v, r_vs, 4'($urandom), r_vm, 2'($urandom));
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vreg_read_arbiter.md
Name: vreg_read_arbiter

Overview:
- Request side of the vector operand-collection path.
- Takes one operand-read request per instruction: up to READ_PORTS vector sources and MASK_PORTS mask sources.
- Schedules those reads onto a banked vector register file, which gives one read per bank per cycle, and onto a single-port mask file. When bank conflicts occur, the reads are spread over several cycles.
- Returns data to the downstream operand buffer with per-port valid pulses, a no_conflict flag and a last flag.

Parameters:
- READ_PORTS, 4: vector source operands per request.
- MASK_PORTS, 2: mask source operands per request.
- NUM_BANKS, 4: vector register file banks, power of two; bank = idx[log2(NUM_BANKS)-1:0].
- REG_IDX_W, 6: vector register index width.
- MASK_IDX_W, 3: mask register index width.
- DATA_W, 512: vector register width; mask width is DATA_W/8.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the pending request and of in-flight responses
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_vs  in  READ_PORTS*REG_IDX_W  source register indices
- req_ven  in  READ_PORTS  per-port operand enable
- req_vm  in  MASK_PORTS*MASK_IDX_W  mask register indices
- req_men  in  MASK_PORTS  per-port mask enable
- bank_ren  out  NUM_BANKS  bank read enables
- bank_raddr  out  NUM_BANKS*(REG_IDX_W-log2(NUM_BANKS))  in-bank row addresses
- bank_rdata  in  NUM_BANKS*DATA_W  bank data, valid one cycle after bank_ren
- mask_ren  out  1  mask file read enable
- mask_raddr  out  MASK_IDX_W  mask file address
- mask_rdata  in  DATA_W/8  mask data, valid one cycle after mask_ren
- dvalid  out  READ_PORTS  per-port vector data valid, one-cycle pulse
- vreg_out  out  READ_PORTS*DATA_W  per-port vector data
- mvalid  out  MASK_PORTS  per-port mask valid pulse
- vmask_out  out  MASK_PORTS*DATA_W/8  per-port mask data
- no_conflict  out  1  request fully delivered in a single response cycle
- last  out  1  final response cycle of the request

Behaviour:
- FSM has two states, IDLE and ISSUE.
  - req_ready = IDLE | (ISSUE & final_issue).
  - On accept, the request is latched into pend_v[READ_PORTS] = req_ven and pend_m[MASK_PORTS] = req_men, plus the indices. Next state is ISSUE.
  - ISSUE stays until final_issue, where final_issue means no pending bits remain after the current grants. Then it goes to IDLE, or back to ISSUE if a new request is accepted in that same cycle. This gives back-to-back requests with no bubble.
  - A request with all enables 0 still takes one ISSUE cycle with no reads.
- Vector grant, each ISSUE cycle, per bank:
  - The lowest-index pending port mapping to that bank wins.
  - Every pending port with a register index identical to the winner is granted in the same access (dedupe).
  - bank_ren[b] = 1 and bank_raddr[b] = winner idx >> log2(NUM_BANKS).
  - Granted bits clear from pend_v.
- Mask grant, each ISSUE cycle:
  - The lowest pending mask port wins, with the same dedupe rule.
  - mask_ren = 1 and mask_raddr = winner index.
- Response timing: response cycle = issue cycle + 1.
  - dvalid[i] is the registered grant of port i.
  - vreg_out[i] = bank_rdata[bank(i)] when dvalid[i], else 0.
  - mvalid and vmask_out follow the same rule from mask_rdata.
- Disabled ports (ven = 0 or men = 0) pulse their valid, with zero data, in the request's first response cycle. This guarantees that every port sees exactly one valid pulse per request.
- last = 1 in the response cycle following final_issue.
- no_conflict = 1 only when the first response cycle is also the last, and 0 in every response cycle of a multi-cycle request.
- Outputs are 0 when there is no response.
- flush:
  - Clears pend_v, pend_m and the registered response stage, so no valid, last or no_conflict appears in the next cycle.
  - FSM goes to IDLE, and a request presented in the flush cycle is not accepted (req_ready = 0).
  - flush wins over simultaneous accept.
- Reset, including mid-operation: state IDLE, all pending bits and response registers 0. Outputs at reset are req_ready = 1, bank_ren = 0, mask_ren = 0, dvalid = 0, mvalid = 0, no_conflict = 0, last = 0, and all data/address outputs 0.
- No back-pressure from the consumer: it must sink every response pulse.

Test Plan:
- No conflict: vs = {1,2,3,4}, ven = 1111, vm = {0,0}, men = 11 → one ISSUE cycle with bank_ren = 1111 and a single mask read. Next cycle dvalid = 1111, mvalid = 11, no_conflict = 1, last = 1.
- Conflict: vs = {1,5,9,2} (banks 1,1,1,2) → issues grant {p0,p3}, then {p1}, then {p2}. Responses dvalid = 1001, 0010, 0100; last only on the third; no_conflict = 0 throughout.
- Dedupe: vs = {7,7,7,7}, vm = {3,3} → one bank_ren (bank 3, row 1) and one mask_ren. Next cycle dvalid = 1111, mvalid = 11, no_conflict = 1.
- Disabled ports: ven = 0101, vs0 = 1, vs2 = 5, men = 00 → first response dvalid = 1011 (ports 1 and 3 with zero data), mvalid = 11; second response dvalid = 0100, last = 1.
- Back-to-back: request A (conflict, 2 issues) with request B held valid → B accepted on A's final_issue cycle, and B's first issue is the very next cycle with no bubble.
- Reset/flush mid-operation: flush asserted during the second issue of the 3-cycle conflict case → no further dvalid or last, FSM in IDLE. Repeating the case with nRST low gives all outputs 0 and req_ready = 1 asynchronously.
